core_stage_mem: RTL and testbench

MEM stage of the core: accepts one load/store request per handshake from the EXEC stage (address, write data, direction, size) and performs it on the word-wide data bus. It performs byte-lane steering, write-strobe generation and misalignment detection. For loads, it sign- or zero-extends the returned data. It holds the controller off until the access completes and presents load data to the write-back mux.

---
 rtl/core_stage_mem.sv | 149 ++++++++++++++
 tb/tb_core_stage_mem.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/core_stage_mem.sv
// MEM stage: one load/store per handshake on a word-wide data bus, with byte-lane
// steering, write strobes, misalignment detection and load sign/zero extension.
package core_pkg;
  typedef enum logic {MEM_READ = 1'b0, MEM_WRITE = 1'b1} mem_dir_e;
  typedef enum logic [2:0] {MEM_B, MEM_BU, MEM_H, MEM_HU, MEM_W} mem_size_e;
endpackage

module core_stage_mem (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mem_stage_valid,
  output logic                 mem_stage_ready,
  input  logic [31:0]          mem_addr,
  input  logic [31:0]          mem_wdata,
  input  core_pkg::mem_dir_e   mem_dir,
  input  core_pkg::mem_size_e  mem_size,
  output logic [31:0]          mem_rdata,
  output logic                 mem_misaligned,
  output logic                 dbus_req_valid,
  input  logic                 dbus_req_ready,
  output logic [31:0]          dbus_addr,
  output logic                 dbus_we,
  output logic [3:0]           dbus_wstrb,
  output logic [31:0]          dbus_wdata,
  input  logic                 dbus_resp_valid,
  input  logic [31:0]          dbus_rdata
);
  import core_pkg::*;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, wdata_q;
  mem_dir_e    dir_q;
  mem_size_e   size_q;
  logic [31:0] rdata_q, rdata_d;
  logic        mis_q, mis_d;
  logic        latch;
  logic        misaligned_in;
  logic [1:0]  off;
  logic [31:0] shifted;
  logic [31:0] load_ext;

  always_comb begin
    misaligned_in = 1'b0;
    case (mem_size)
      MEM_H, MEM_HU: misaligned_in = mem_addr[0];
      MEM_W:         misaligned_in = (mem_addr[1:0] != 2'b00);
      default:       misaligned_in = 1'b0;
    endcase
  end

  assign off     = addr_q[1:0];
  assign shifted = dbus_rdata >> {off, 3'b000};

  always_comb begin
    load_ext = shifted;
    case (size_q)
      MEM_B:   load_ext = {{24{shifted[7]}}, shifted[7:0]};
      MEM_BU:  load_ext = {24'h000000, shifted[7:0]};
      MEM_H:   load_ext = {{16{shifted[15]}}, shifted[15:0]};
      MEM_HU:  load_ext = {16'h0000, shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    mis_d   = mis_q;
    latch   = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_stage_valid) begin
          // A new access clears the previous result before anything else happens.
          rdata_d = 32'h0;
          mis_d   = misaligned_in;
          if (misaligned_in) begin
            state_d = DONE;
          end else begin
            latch   = 1'b1;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (dbus_req_ready) state_d = WAIT;
      end
      WAIT: begin
        if (dbus_resp_valid) begin
          rdata_d = (dir_q == MEM_WRITE) ? 32'h0 : load_ext;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      dir_q   <= MEM_READ;
      size_q  <= MEM_B;
      rdata_q <= 32'h0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      mis_q   <= mis_d;
      if (latch) begin
        addr_q  <= mem_addr;
        wdata_q <= mem_wdata;
        dir_q   <= mem_dir;
        size_q  <= mem_size;
      end
    end
  end

  // Bus outputs come only from latched state, so they stay put through REQ stalls.
  always_comb begin
    dbus_wstrb = 4'b0000;
    dbus_wdata = wdata_q;
    case (size_q)
      MEM_B, MEM_BU: begin
        dbus_wstrb = 4'b0001 << off;
        dbus_wdata = {4{wdata_q[7:0]}};
      end
      MEM_H, MEM_HU: begin
        dbus_wstrb = 4'b0011 << off;
        dbus_wdata = {2{wdata_q[15:0]}};
      end
      default: begin
        dbus_wstrb = 4'b1111;
        dbus_wdata = wdata_q;
      end
    endcase
    if (dir_q != MEM_WRITE) dbus_wstrb = 4'b0000;
  end

  assign dbus_req_valid  = (state_q == REQ);
  assign dbus_addr       = {addr_q[31:2], 2'b00};
  assign dbus_we         = (dir_q == MEM_WRITE);
  assign mem_stage_ready = (state_q == DONE);
  assign mem_rdata       = rdata_q;
  assign mem_misaligned  = mis_q;

endmodule

// File: tb/tb_core_stage_mem.sv
// Directed bench for core_stage_mem: expected bus requests and stage responses are
// queued at issue time and compared by independent negedge monitors.
module tb_core_stage_mem;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_stage_valid = 1'b0;
  logic        mem_stage_ready;
  logic [31:0] mem_addr = 32'h0;
  logic [31:0] mem_wdata = 32'h0;
  mem_dir_e    mem_dir = MEM_READ;
  mem_size_e   mem_size = MEM_W;
  logic [31:0] mem_rdata;
  logic        mem_misaligned;
  logic        dbus_req_valid;
  logic        dbus_req_ready = 1'b0;
  logic [31:0] dbus_addr;
  logic        dbus_we;
  logic [3:0]  dbus_wstrb;
  logic [31:0] dbus_wdata;
  logic        dbus_resp_valid = 1'b0;
  logic [31:0] dbus_rdata = 32'h0;

  core_stage_mem dut (
    .clk(clk), .rst(rst),
    .mem_stage_valid(mem_stage_valid), .mem_stage_ready(mem_stage_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_dir(mem_dir), .mem_size(mem_size),
    .mem_rdata(mem_rdata), .mem_misaligned(mem_misaligned),
    .dbus_req_valid(dbus_req_valid), .dbus_req_ready(dbus_req_ready),
    .dbus_addr(dbus_addr), .dbus_we(dbus_we), .dbus_wstrb(dbus_wstrb),
    .dbus_wdata(dbus_wdata), .dbus_resp_valid(dbus_resp_valid), .dbus_rdata(dbus_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  int start_cyc = 0;
  int ready_cyc = 1000;
  int resp_cyc = 1000;
  int bus_rel;
  logic [31:0] bus_rd = 32'h0;

  typedef struct { logic [31:0] rdata; logic mis; int lat; } resp_t;
  typedef struct { logic [31:0] addr; logic we; logic [3:0] wstrb; logic [31:0] wdata; } bus_t;
  resp_t sb_q[$];
  bus_t  bus_q[$];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Bus model driven on negedge, relative to the start cycle of the current op;
  // it also checks every presented request against the expected one.
  always @(negedge clk) begin
    bus_rel = cyc - start_cyc;
    dbus_req_ready  = (bus_rel == ready_cyc);
    dbus_resp_valid = (bus_rel == resp_cyc);
    dbus_rdata      = bus_rd;
    if (dbus_req_valid) begin
      if (bus_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_req: got dbus_req_valid=1 addr=%h expected none", dbus_addr);
      end else begin
        check32("dbus_addr", dbus_addr, bus_q[0].addr);
        check32("dbus_we", {31'h0, dbus_we}, {31'h0, bus_q[0].we});
        check32("dbus_wstrb", {28'h0, dbus_wstrb}, {28'h0, bus_q[0].wstrb});
        if (bus_q[0].we) check32("dbus_wdata", dbus_wdata, bus_q[0].wdata);
        if (dbus_req_ready) void'(bus_q.pop_front());
      end
    end
  end

  // Response monitor: every mem_stage_ready cycle must match a queued expectation.
  always @(negedge clk) begin
    if (mem_stage_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready: got mem_stage_ready=1 at cycle %0d expected none", cyc - start_cyc);
      end else begin
        resp_t e;
        e = sb_q.pop_front();
        check32("mem_rdata", mem_rdata, e.rdata);
        check32("mem_misaligned", {31'h0, mem_misaligned}, {31'h0, e.mis});
        check32("ready_latency", cyc - start_cyc, e.lat);
      end
    end
  end

  task automatic op(input logic [31:0] a, input logic [31:0] d, input mem_dir_e dir,
                    input mem_size_e sz, input logic [31:0] rd, input int rdy_c, input int rsp_c,
                    input logic [31:0] exp_rdata, input logic exp_mis, input int exp_lat,
                    input logic [3:0] exp_strb, input logic [31:0] exp_wd);
    resp_t r;
    bus_t  b;
    bit    got;
    r.rdata = exp_rdata; r.mis = exp_mis; r.lat = exp_lat;
    sb_q.push_back(r);
    if (!exp_mis) begin
      b.addr = {a[31:2], 2'b00}; b.we = (dir == MEM_WRITE); b.wstrb = exp_strb; b.wdata = exp_wd;
      bus_q.push_back(b);
    end
    mem_addr = a; mem_wdata = d; mem_dir = dir; mem_size = sz;
    start_cyc = cyc; ready_cyc = rdy_c; resp_cyc = rsp_c; bus_rd = rd;
    mem_stage_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (mem_stage_ready) begin
        got = 1'b1;
        break;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL timeout: got no mem_stage_ready for addr=%h expected one within 30 cycles", a);
      sb_q.delete();
      bus_q.delete();
    end else if (bus_q.size() != 0) begin
      errors++;
      $display("FAIL missing_req: got %0d unaccepted requests expected 0", bus_q.size());
      bus_q.delete();
    end
    $display("op addr=%h dir=%0d size=%0d rdata=%h misaligned=%0d", a, dir, sz, mem_rdata, mem_misaligned);
    @(posedge clk);
    #1;
    mem_stage_valid = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check32("rst_req_valid", {31'h0, dbus_req_valid}, 32'h0);
    check32("rst_stage_ready", {31'h0, mem_stage_ready}, 32'h0);
    check32("rst_rdata", mem_rdata, 32'h0);
    check32("rst_misaligned", {31'h0, mem_misaligned}, 32'h0);
    check32("rst_addr", dbus_addr, 32'h0);
    check32("rst_we", {31'h0, dbus_we}, 32'h0);
    check32("rst_wstrb", {28'h0, dbus_wstrb}, 32'h0);
    check32("rst_wdata", dbus_wdata, 32'h0);
    @(posedge clk);
    #1;

    // addr, wdata, dir, size, bus rdata, ready cyc, resp cyc, exp rdata, exp mis, exp lat, strb, bus wdata
    op(32'h100, 32'hDEADBEEF, MEM_WRITE, MEM_W,  32'h0, 1, 2, 32'h0, 1'b0, 3, 4'b1111, 32'hDEADBEEF);
    op(32'h203, 32'h000000A5, MEM_WRITE, MEM_B,  32'h0, 1, 2, 32'h0, 1'b0, 3, 4'b1000, 32'hA5A5A5A5);
    op(32'h202, 32'h00001234, MEM_WRITE, MEM_H,  32'h0, 1, 2, 32'h0, 1'b0, 3, 4'b1100, 32'h12341234);
    op(32'h101, 32'h0, MEM_READ, MEM_B,  32'h80F17F01, 1, 2, 32'h0000007F, 1'b0, 3, 4'b0000, 32'h0);
    op(32'h102, 32'h0, MEM_READ, MEM_B,  32'h80F17F01, 1, 2, 32'hFFFFFFF1, 1'b0, 3, 4'b0000, 32'h0);
    op(32'h103, 32'h0, MEM_READ, MEM_BU, 32'h80F17F01, 1, 2, 32'h00000080, 1'b0, 3, 4'b0000, 32'h0);
    op(32'h103, 32'h0, MEM_READ, MEM_B,  32'h80F17F01, 1, 2, 32'hFFFFFF80, 1'b0, 3, 4'b0000, 32'h0);
    op(32'h102, 32'h0, MEM_READ, MEM_H,  32'h80F17F01, 1, 2, 32'hFFFF80F1, 1'b0, 3, 4'b0000, 32'h0);
    op(32'h102, 32'h0, MEM_READ, MEM_HU, 32'h80F17F01, 1, 2, 32'h000080F1, 1'b0, 3, 4'b0000, 32'h0);
    op(32'h100, 32'h0, MEM_READ, MEM_H,  32'h80F17F01, 1, 2, 32'h00007F01, 1'b0, 3, 4'b0000, 32'h0);
    op(32'h100, 32'h0, MEM_READ, MEM_W,  32'h80F17F01, 1, 2, 32'h80F17F01, 1'b0, 3, 4'b0000, 32'h0);
    // Misaligned right after a nonzero load: result must clear, no bus request.
    op(32'h102, 32'h0, MEM_READ, MEM_W,  32'h80F17F01, 99, 99, 32'h0, 1'b1, 1, 4'b0000, 32'h0);
    op(32'h101, 32'h0000BEEF, MEM_WRITE, MEM_H, 32'h0, 99, 99, 32'h0, 1'b1, 1, 4'b0000, 32'h0);
    // Stalled store: request held three cycles, response two cycles after acceptance.
    op(32'h302, 32'h0000BEEF, MEM_WRITE, MEM_H, 32'h0, 3, 5, 32'h0, 1'b0, 6, 4'b1100, 32'hBEEFBEEF);

    // Reset while waiting for a response; the late response must be ignored.
    begin
      bus_t b;
      b.addr = 32'h500; b.we = 1'b0; b.wstrb = 4'b0000; b.wdata = 32'h0;
      bus_q.push_back(b);
      mem_addr = 32'h500; mem_dir = MEM_READ; mem_size = MEM_W; mem_wdata = 32'h0;
      start_cyc = cyc; ready_cyc = 1; resp_cyc = 3; bus_rd = 32'h11111111;
      mem_stage_valid = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      mem_stage_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check32("post_rst_req_valid", {31'h0, dbus_req_valid}, 32'h0);
      check32("post_rst_stage_ready", {31'h0, mem_stage_ready}, 32'h0);
      check32("post_rst_rdata", mem_rdata, 32'h0);
      check32("post_rst_wstrb", {28'h0, dbus_wstrb}, 32'h0);
      check32("post_rst_addr", dbus_addr, 32'h0);
      @(negedge clk);
      check32("post_rst_idle_ready", {31'h0, mem_stage_ready}, 32'h0);
      check32("post_rst_idle_req", {31'h0, dbus_req_valid}, 32'h0);
      check32("rst_req_accepted", bus_q.size(), 32'h0);
      bus_q.delete();
      $display("op addr=00000500 dir=0 size=4 interrupted by reset");
      @(posedge clk); #1;
    end

    op(32'h400, 32'h0, MEM_READ, MEM_W, 32'hCAFEF00D, 1, 2, 32'hCAFEF00D, 1'b0, 3, 4'b0000, 32'h0);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
